// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: scan-result and
// debounce-state enums, row strobe patterns and the row/column to key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_KEY,
    RES_MULTI
  } scan_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_PEND,
    ST_HELD,
    ST_REL_PEND
  } key_state_e;

  typedef struct packed {
    scan_kind_e kind;
    logic [3:0] code;
  } scan_result_t;

  localparam logic [3:0] ROW0_STROBE = 4'b1110;
  localparam logic [3:0] ROW1_STROBE = 4'b1101;
  localparam logic [3:0] ROW2_STROBE = 4'b1011;
  localparam logic [3:0] ROW3_STROBE = 4'b0111;

  function automatic logic [3:0] row_strobe(input logic [1:0] row);
    unique case (row)
      2'd0:    return ROW0_STROBE;
      2'd1:    return ROW1_STROBE;
      2'd2:    return ROW2_STROBE;
      default: return ROW3_STROBE;
    endcase
  endfunction

  // Column index is the position of the low bit in the column sample.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    unique case ({row, col})
      4'b00_00: return 4'h7;
      4'b00_01: return 4'h4;
      4'b00_10: return 4'h1;
      4'b00_11: return 4'h0;
      4'b01_00: return 4'h8;
      4'b01_01: return 4'h5;
      4'b01_10: return 4'h2;
      4'b01_11: return 4'hA;
      4'b10_00: return 4'h9;
      4'b10_01: return 4'h6;
      4'b10_10: return 4'h3;
      4'b10_11: return 4'hB;
      4'b11_00: return 4'hC;
      4'b11_01: return 4'hD;
      4'b11_10: return 4'hE;
      default:  return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for confirmed key codes; a push into a full FIFO is
// dropped (unless a pop frees a slot that cycle) and reported one cycle later.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             drop_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign drop_o  = drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW + 1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW + 1)'(1);
      drop_q <= push_i && !do_push;
    end
  end

  // NOTE: storage has no reset; occupancy gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: strobes rows, classifies each full scan, debounces
// press/release across scans and queues one code per confirmed press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypad_col,
  output logic [3:0] keypad_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);
  localparam int DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_SCANS);

  logic [DW-1:0] dwell_q;
  logic [1:0]    row_q, hit_cnt_q;
  logic          multi_q;
  logic [3:0]    acc_code_q;
  scan_result_t  prev_q, prev_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d, deb_next;
  key_state_e    state_q, state_d;
  logic [3:0]    latched_q, latched_d;
  logic          push_q, push_d;

  logic          sample, scan_done, confirmed, key_match, fifo_empty, fifo_full;
  logic [2:0]    zero_cnt;
  logic [1:0]    zero_idx, hits_now;
  logic          multi_now;
  logic [3:0]    code_now;
  scan_result_t  result;

  assign sample     = (dwell_q == DWELL_LAST);
  assign scan_done  = sample && (row_q == 2'd3);
  assign keypad_row = row_strobe(row_q);

  // Fold this row's sample into the running scan; result is meaningful on scan_done.
  always_comb begin
    zero_cnt = '0;
    zero_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (!keypad_col[i]) begin
        zero_cnt = zero_cnt + 3'd1;
        zero_idx = 2'(i);
      end
    end
    hits_now  = hit_cnt_q;
    multi_now = multi_q || (zero_cnt > 3'd1);
    code_now  = acc_code_q;
    if (zero_cnt == 3'd1) begin
      hits_now = (hit_cnt_q == 2'd2) ? 2'd2 : hit_cnt_q + 2'd1;
      code_now = key_map(row_q, zero_idx);
    end
    result.kind = RES_NONE;
    result.code = 4'h0;
    if (multi_now || hits_now == 2'd2) begin
      result.kind = RES_MULTI;
    end else if (hits_now == 2'd1) begin
      result.kind = RES_KEY;
      result.code = code_now;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q    <= '0;
      row_q      <= '0;
      hit_cnt_q  <= '0;
      multi_q    <= 1'b0;
      acc_code_q <= '0;
    end else if (sample) begin
      dwell_q <= '0;
      row_q   <= row_q + 2'd1;
      if (scan_done) begin
        hit_cnt_q  <= '0;
        multi_q    <= 1'b0;
        acc_code_q <= '0;
      end else begin
        hit_cnt_q  <= hits_now;
        multi_q    <= multi_now;
        acc_code_q <= code_now;
      end
    end else begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  // MULTI always restarts the count so a ghost pattern can never confirm.
  assign deb_next  = (result.kind != RES_MULTI && result == prev_q)
                     ? ((deb_cnt_q >= DEB_MAX) ? DEB_MAX : deb_cnt_q + CW'(1))
                     : CW'(1);
  assign confirmed = (deb_next == DEB_MAX);
  assign key_match = (result.kind == RES_KEY) && (result.code == latched_q);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    prev_d    = prev_q;
    latched_d = latched_q;
    push_d    = 1'b0;
    if (scan_done) begin
      prev_d    = result;
      deb_cnt_d = deb_next;
      unique case (state_q)
        ST_IDLE, ST_PRESS_PEND: begin
          if (result.kind == RES_KEY) begin
            if (confirmed) begin
              state_d   = ST_HELD;
              latched_d = result.code;
              push_d    = 1'b1;
            end else begin
              state_d = ST_PRESS_PEND;
            end
          end else if (result.kind == RES_NONE) begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (result.kind == RES_NONE) begin
            state_d = confirmed ? ST_IDLE : ST_REL_PEND;
          end else if (result.kind == RES_KEY && !key_match) begin
            state_d = ST_REL_PEND;
          end
        end
        ST_REL_PEND: begin
          if (result.kind == RES_NONE && confirmed) begin
            state_d = ST_IDLE;
          end else if (key_match) begin
            state_d = ST_HELD;
          end else if (result.kind == RES_KEY) begin
            state_d   = ST_PRESS_PEND;
            deb_cnt_d = CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      deb_cnt_q <= '0;
      prev_q    <= '{kind: RES_NONE, code: 4'h0};
      latched_q <= '0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      prev_q    <= prev_d;
      latched_q <= latched_d;
      push_q    <= push_d;
    end
  end

  assign key_held  = (state_q == ST_HELD) || (state_q == ST_REL_PEND);
  assign key_valid = !fifo_empty;

  key_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(4)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push_q),
    .data_i (latched_q),
    .pop_i  (key_ready),
    .data_o (key_code),
    .empty_o(fifo_empty),
    .full_o (fifo_full),
    .drop_o (overflow)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Sequencer for the 4x4 matrix keypad: drives the active-low row strobes at a programmable dwell, samples the active-low column lines, and resolves each full scan to one key or none. Debounces across consecutive scans and tracks press/hold/release. Delivers one 4-bit key code per confirmed press through a small FIFO with a valid/ready handshake. Sits between the keypad pins and the consumer logic, such as the display or command decoder.

## Interface
- SETTLE_CYCLES, 16: dwell per row in clk cycles (>=2); columns sampled on the last dwell cycle
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required to confirm press or release (>=1)
- FIFO_DEPTH, 4: key-code FIFO entries (power of 2)
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- keypad_col  in  4  column inputs, active-low; assumed already synchronised
- keypad_row  out  4  row strobes, active-low, exactly one bit low
- key_code  out  4  FIFO head key code, valid when key_valid=1
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer accepts head; pop on key_valid&key_ready
- key_held  out  1  high while a confirmed key is down (HELD, REL_PEND)
- overflow  out  1  one-cycle pulse when a confirmed press is dropped on a full FIFO

## Operation
- Row sequence: 1110 -> 1101 -> 1011 -> 0111 -> 1110. Each row is held SETTLE_CYCLES cycles. One full scan is 4*SETTLE_CYCLES cycles.
- Key map, row-major, columns ordered 1110, 1101, 1011, 0111:
  - row 1110: 7, 4, 1, 0
  - row 1101: 8, 5, 2, A
  - row 1011: 9, 6, 3, B
  - row 0111: C, D, E, F
- Per-row sample classification: all-ones = none; exactly one zero = single key; otherwise multi.
- Scan result after row 0111 is sampled:
  - NONE: no row hit.
  - KEY(code): exactly one single hit across all rows.
  - MULTI: more than one hit, or any multi row.
- Debounce counter: increments when the result equals the previous result, and resets to 1 otherwise. Saturates at DEBOUNCE_SCANS.
- MULTI is never confirmed. It resets the counter and leaves the FSM state unchanged (no pushes while ghosting).
- FSM states and transitions:
  - IDLE -> PRESS_PEND: on a KEY result.
  - PRESS_PEND -> HELD: on the DEBOUNCE_SCANS-th consecutive identical KEY. Latch the code and push it.
  - PRESS_PEND -> IDLE: on NONE.
  - PRESS_PEND restarts the count: on a different KEY.
  - HELD stays HELD: on a KEY equal to the latched code. No repeat push.
  - HELD -> REL_PEND: on NONE, or on a different KEY.
  - REL_PEND -> IDLE: on DEBOUNCE_SCANS consecutive NONE results.
  - REL_PEND -> HELD: on the latched KEY.
  - REL_PEND -> PRESS_PEND: on a different KEY, with the counter restarting at 1.
- FIFO behaviour:
  - Push when not full.
  - If full, drop the new code and pulse overflow. Existing contents are unchanged.
  - Pop on key_valid&key_ready.
  - Push and pop in the same cycle while full: both take effect, and nothing is dropped.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - keypad_row=1110
  - key_code=0, key_valid=0, key_held=0, overflow=0
  - FSM=IDLE, dwell/row/debounce counters=0
  - FIFO empty, previous result=NONE
- Reset mid-scan or mid-debounce abandons all progress. The next cycle starts at row 1110, dwell count 0.
- Let cycle T be the cycle in which row 0111 is sampled. Then:
  - The FSM and counter update at the edge ending T.
  - The push, and any overflow pulse, occur at the edge ending T+1.
  - key_valid is high from cycle T+2 if the FIFO was empty.
  - key_held rises at T+1 and falls at T+1 of the confirming release scan.
- keypad_row changes on the edge ending the sample cycle. Column sampling never occurs in the first SETTLE_CYCLES-1 cycles of a row.
- key_code is stable while key_valid=1 and no pop occurs.

## Structure
- Package keypad_pkg:
  - scan-result enum (NONE/KEY/MULTI)
  - FSM state enum (IDLE/PRESS_PEND/HELD/REL_PEND)
  - row strobe constants
  - key-map function (row, col) -> code
- Sub-module key_fifo: parameterised sync FIFO with push/pop/full/empty and drop-on-full. The top level holds the scanner, classifier and debounce FSM.

## Test plan
Bench parameters: SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4.
- Reset, no keys: keypad_row cycles 1110/1101/1011/0111 every 4 cycles; key_valid=0 and key_held=0 throughout.
- Press key '5' (col 1101 low while row 1101) for 3 scans with key_ready=1:
  - exactly one pop, of code 5;
  - key_valid first high 2 cycles after the 2nd scan's row-0111 sample;
  - key_held=1 until 2 NONE scans after release.
- Bounce: '5' present in one scan, absent in the next, then stable: only one code 5 is pushed, after 2 consecutive stable scans.
- Ghost: keys 1 and 2 held together → MULTI; no push, key_held unchanged; releasing to '2' alone yields code 2.
- key_ready=0, press and release A, B, C, D, E in turn:
  - FIFO holds A, B, C, D;
  - overflow pulses once on E;
  - subsequent pops return A, B, C, D in order.
- Assert reset while in PRESS_PEND with 3 codes queued: the next cycle shows key_valid=0 and keypad_row=1110, and the held key needs the full debounce again.
